// File: rtl/frame_ram_pkg.sv
// Shared encodings and frame-buffer layout constants for the SDRAM port arbiter.
// Client IDs double as slot indices in the arbiter.
package frame_ram_pkg;

    typedef enum logic [1:0] {
        CLI_VGA = 2'd0,
        CLI_CAM = 2'd1,
        CLI_HDR = 2'd2
    } client_e;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } state_e;

    localparam int unsigned FRAME_BURSTS  = 38400;
    localparam int unsigned CAM_BASE_ADDR = 0;
    localparam int unsigned HDR_BASE_ADDR = 38400;
    localparam int unsigned VGA_BASE_ADDR = 38400;

    function automatic int unsigned offset_width(input int unsigned bursts);
        return (bursts > 1) ? $clog2(bursts) : 1;
    endfunction

endpackage

// File: rtl/frame_ram_arbiter_slot.sv
// One client slot: single-entry request buffer, sticky drop flag and a
// wrapping burst-offset counter restarted by frame_start.
module arb_client_slot #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned OFFS_W   = 16,
    parameter int unsigned BURSTS   = 38400,
    parameter bit          HAS_DATA = 1'b1,
    parameter bit          HAS_OVF  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [DATA_W-1:0] data,
    input  logic              frame_start,
    input  logic              grant,
    output logic              pending,
    output logic [DATA_W-1:0] data_out,
    output logic [OFFS_W-1:0] offset,
    output logic              overflow
);

    logic              pending_q, pending_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [OFFS_W-1:0] offset_q, offset_d;
    logic              overflow_q, overflow_d;
    logic              accept;

    always_comb begin
        // A request landing on the grant cycle refills the slot instead of being dropped.
        accept     = req & (~pending_q | grant);

        pending_d  = pending_q;
        if (grant) pending_d = 1'b0;
        if (req)   pending_d = 1'b1;

        data_d     = data_q;
        if (HAS_DATA && accept) data_d = data;

        overflow_d = overflow_q;
        if (HAS_OVF && req && !accept) overflow_d = 1'b1;

        offset_d   = offset_q;
        if (frame_start) begin
            offset_d = '0;
        end else if (grant) begin
            offset_d = (offset_q == OFFS_W'(BURSTS - 1)) ? '0 : offset_q + OFFS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= 1'b0;
            data_q     <= '0;
            offset_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            data_q     <= data_d;
            offset_q   <= offset_d;
            overflow_q <= overflow_d;
        end
    end

    assign pending  = pending_q;
    assign data_out = data_q;
    assign offset   = offset_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/frame_ram_arbiter.sv
// Shares one SDRAM controller port between camera writes, HDR writes and VGA reads.
// VGA reads have strict priority; the two writers alternate round-robin.
module frame_ram_arbiter #(
    parameter int unsigned DATA_W           = 128,
    parameter int unsigned ADDR_W           = 22,
    parameter int unsigned BURSTS_PER_FRAME = frame_ram_pkg::FRAME_BURSTS,
    parameter int unsigned CAM_BASE         = frame_ram_pkg::CAM_BASE_ADDR,
    parameter int unsigned HDR_BASE         = frame_ram_pkg::HDR_BASE_ADDR,
    parameter int unsigned VGA_BASE         = frame_ram_pkg::VGA_BASE_ADDR
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cam_wr_req,
    input  logic [DATA_W-1:0] cam_wr_data,
    input  logic              cam_frame_start,
    input  logic              hdr_wr_req,
    input  logic [DATA_W-1:0] hdr_wr_data,
    input  logic              hdr_frame_start,
    input  logic              vga_rd_req,
    input  logic              vga_frame_start,
    output logic [DATA_W-1:0] vga_rd_data,
    output logic              vga_rd_valid,
    input  logic              ram_busy,
    input  logic              ram_rd_valid,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              ram_wr_req,
    output logic              ram_rd_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              cam_overflow,
    output logic              hdr_overflow
);

    import frame_ram_pkg::*;

    localparam int unsigned OFFS_W = offset_width(BURSTS_PER_FRAME);

    state_e            state_q, state_d;
    logic              rr_q, rr_d;  // 0: camera has the turn, 1: HDR has the turn
    logic              ram_wr_req_q, ram_wr_req_d;
    logic              ram_rd_req_q, ram_rd_req_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wr_data_q, ram_wr_data_d;
    logic              vga_rd_valid_q;
    logic [DATA_W-1:0] vga_rd_data_q;

    logic              pend_vga, pend_cam, pend_hdr;
    logic              grant_vga, grant_cam, grant_hdr;
    logic [OFFS_W-1:0] off_vga, off_cam, off_hdr;
    logic [DATA_W-1:0] cam_buf, hdr_buf;
    logic              unused_vga_ovf;
    logic [DATA_W-1:0] unused_vga_buf;

    client_e           winner;
    logic              issue;
    logic [ADDR_W-1:0] win_addr;

    arb_client_slot #(
        .DATA_W   (DATA_W),
        .OFFS_W   (OFFS_W),
        .BURSTS   (BURSTS_PER_FRAME),
        .HAS_DATA (1'b0),
        .HAS_OVF  (1'b0)
    ) u_slot_vga (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (vga_rd_req),
        .data        ({DATA_W{1'b0}}),
        .frame_start (vga_frame_start),
        .grant       (grant_vga),
        .pending     (pend_vga),
        .data_out    (unused_vga_buf),
        .offset      (off_vga),
        .overflow    (unused_vga_ovf)
    );

    arb_client_slot #(
        .DATA_W   (DATA_W),
        .OFFS_W   (OFFS_W),
        .BURSTS   (BURSTS_PER_FRAME),
        .HAS_DATA (1'b1),
        .HAS_OVF  (1'b1)
    ) u_slot_cam (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (cam_wr_req),
        .data        (cam_wr_data),
        .frame_start (cam_frame_start),
        .grant       (grant_cam),
        .pending     (pend_cam),
        .data_out    (cam_buf),
        .offset      (off_cam),
        .overflow    (cam_overflow)
    );

    arb_client_slot #(
        .DATA_W   (DATA_W),
        .OFFS_W   (OFFS_W),
        .BURSTS   (BURSTS_PER_FRAME),
        .HAS_DATA (1'b1),
        .HAS_OVF  (1'b1)
    ) u_slot_hdr (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (hdr_wr_req),
        .data        (hdr_wr_data),
        .frame_start (hdr_frame_start),
        .grant       (grant_hdr),
        .pending     (pend_hdr),
        .data_out    (hdr_buf),
        .offset      (off_hdr),
        .overflow    (hdr_overflow)
    );

    always_comb begin
        issue  = 1'b0;
        winner = CLI_VGA;
        if (state_q == IDLE && !ram_busy && (pend_vga || pend_cam || pend_hdr)) begin
            issue = 1'b1;
            if (pend_vga) begin
                winner = CLI_VGA;
            end else if (rr_q) begin
                winner = pend_hdr ? CLI_HDR : CLI_CAM;
            end else begin
                winner = pend_cam ? CLI_CAM : CLI_HDR;
            end
        end
        grant_vga = issue && (winner == CLI_VGA);
        grant_cam = issue && (winner == CLI_CAM);
        grant_hdr = issue && (winner == CLI_HDR);
    end

    // Address math is deliberately modulo 2**ADDR_W.
    always_comb begin
        unique case (winner)
            CLI_CAM: win_addr = ADDR_W'(CAM_BASE) + ADDR_W'(off_cam);
            CLI_HDR: win_addr = ADDR_W'(HDR_BASE) + ADDR_W'(off_hdr);
            default: win_addr = ADDR_W'(VGA_BASE) + ADDR_W'(off_vga);
        endcase
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        ram_wr_req_d  = 1'b0;
        ram_rd_req_d  = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;

        unique case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d    = GAP;
                    ram_addr_d = win_addr;
                    if (winner == CLI_VGA) begin
                        ram_rd_req_d = 1'b1;
                    end else begin
                        ram_wr_req_d  = 1'b1;
                        ram_wr_data_d = (winner == CLI_CAM) ? cam_buf : hdr_buf;
                        rr_d          = ~rr_q;
                    end
                end
            end
            // Lets the controller's busy rise become visible before the next issue.
            GAP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rr_q           <= 1'b0;
            ram_wr_req_q   <= 1'b0;
            ram_rd_req_q   <= 1'b0;
            ram_addr_q     <= '0;
            ram_wr_data_q  <= '0;
            vga_rd_valid_q <= 1'b0;
            vga_rd_data_q  <= '0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            ram_wr_req_q   <= ram_wr_req_d;
            ram_rd_req_q   <= ram_rd_req_d;
            ram_addr_q     <= ram_addr_d;
            ram_wr_data_q  <= ram_wr_data_d;
            vga_rd_valid_q <= ram_rd_valid;
            vga_rd_data_q  <= ram_rd_data;
        end
    end

    assign ram_wr_req   = ram_wr_req_q;
    assign ram_rd_req   = ram_rd_req_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wr_data  = ram_wr_data_q;
    assign vga_rd_valid = vga_rd_valid_q;
    assign vga_rd_data  = vga_rd_data_q;

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Bench for frame_ram_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the arbitration rules.
module tb_frame_ram_arbiter;

    localparam int unsigned DW  = 128;
    localparam int unsigned AW  = 22;
    localparam int unsigned BPF = 38400;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cam_wr_req, cam_frame_start, hdr_wr_req, hdr_frame_start;
    logic          vga_rd_req, vga_frame_start;
    logic [DW-1:0] cam_wr_data, hdr_wr_data;
    logic [DW-1:0] vga_rd_data;
    logic          vga_rd_valid;
    logic          ram_busy, ram_rd_valid;
    logic [DW-1:0] ram_rd_data;
    logic          ram_wr_req, ram_rd_req;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wr_data;
    logic          cam_overflow, hdr_overflow;

    frame_ram_arbiter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cam_wr_req      (cam_wr_req),
        .cam_wr_data     (cam_wr_data),
        .cam_frame_start (cam_frame_start),
        .hdr_wr_req      (hdr_wr_req),
        .hdr_wr_data     (hdr_wr_data),
        .hdr_frame_start (hdr_frame_start),
        .vga_rd_req      (vga_rd_req),
        .vga_frame_start (vga_frame_start),
        .vga_rd_data     (vga_rd_data),
        .vga_rd_valid    (vga_rd_valid),
        .ram_busy        (ram_busy),
        .ram_rd_valid    (ram_rd_valid),
        .ram_rd_data     (ram_rd_data),
        .ram_wr_req      (ram_wr_req),
        .ram_rd_req      (ram_rd_req),
        .ram_addr        (ram_addr),
        .ram_wr_data     (ram_wr_data),
        .cam_overflow    (cam_overflow),
        .hdr_overflow    (hdr_overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state; index 0 = VGA, 1 = camera, 2 = HDR.
    int unsigned   base [3] = '{38400, 0, 38400};
    logic          m_pend [3];
    logic [DW-1:0] m_data [3];
    int unsigned   m_off  [3];
    logic          m_ovf  [3];
    logic          m_turn_hdr;
    logic          m_gap;
    logic          e_wr, e_rd, e_vv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_vd;

    // Controller model knobs.
    int   busy_len  = 2;
    int   busy_left = 0;
    logic hold_busy = 1'b0;
    logic rand_rd   = 1'b0;

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pend[i] = 1'b0;
            m_data[i] = '0;
            m_off[i]  = 0;
            m_ovf[i]  = 1'b0;
        end
        m_turn_hdr = 1'b0;
        m_gap      = 1'b0;
        e_wr = 1'b0; e_rd = 1'b0; e_vv = 1'b0;
        e_addr = '0; e_wd = '0; e_vd = '0;
    endtask

    // Which client the arbiter is expected to serve in the current cycle (-1: none).
    function automatic int pred_win();
        if (!rst_n || m_gap || ram_busy) return -1;
        if (m_pend[0]) return 0;
        if (!m_pend[1] && !m_pend[2]) return -1;
        if (m_turn_hdr) return m_pend[2] ? 2 : 1;
        return m_pend[1] ? 1 : 2;
    endfunction

    task automatic model_step();
        int            w;
        logic          req [3];
        logic          fs  [3];
        logic [DW-1:0] din [3];
        if (!rst_n) begin
            model_reset();
            return;
        end
        w = pred_win();
        req = '{vga_rd_req, cam_wr_req, hdr_wr_req};
        fs  = '{vga_frame_start, cam_frame_start, hdr_frame_start};
        din = '{'0, cam_wr_data, hdr_wr_data};
        e_vv = ram_rd_valid;
        e_vd = ram_rd_data;
        e_wr = (w > 0);
        e_rd = (w == 0);
        if (w >= 0) begin
            e_addr = AW'(base[w] + m_off[w]);
            if (w > 0) begin
                e_wd       = m_data[w];
                m_turn_hdr = ~m_turn_hdr;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (fs[i]) m_off[i] = 0;
            else if (w == i) m_off[i] = (m_off[i] + 1) % BPF;
            if (req[i]) begin
                if (m_pend[i] && w != i) begin
                    if (i != 0) m_ovf[i] = 1'b1;
                end else begin
                    m_pend[i] = 1'b1;
                    m_data[i] = din[i];
                end
            end else if (w == i) begin
                m_pend[i] = 1'b0;
            end
        end
        m_gap = (w >= 0);
    endtask

    // One clock: update the model at the edge, compare #1 later, then drive idle inputs.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        checks++;
        if (ram_wr_req !== e_wr) begin
            errors++;
            $display("FAIL cyc_wr_req t=%0t got=%b exp=%b", $time, ram_wr_req, e_wr);
        end
        checks++;
        if (ram_rd_req !== e_rd) begin
            errors++;
            $display("FAIL cyc_rd_req t=%0t got=%b exp=%b", $time, ram_rd_req, e_rd);
        end
        if (e_wr || e_rd) begin
            checks++;
            if (ram_addr !== e_addr) begin
                errors++;
                $display("FAIL cyc_addr t=%0t got=%0d exp=%0d", $time, ram_addr, e_addr);
            end
        end
        if (e_wr) begin
            checks++;
            if (ram_wr_data !== e_wd) begin
                errors++;
                $display("FAIL cyc_wr_data t=%0t got=%h exp=%h", $time, ram_wr_data, e_wd);
            end
        end
        checks++;
        if (vga_rd_valid !== e_vv) begin
            errors++;
            $display("FAIL cyc_vga_valid t=%0t got=%b exp=%b", $time, vga_rd_valid, e_vv);
        end
        if (e_vv) begin
            checks++;
            if (vga_rd_data !== e_vd) begin
                errors++;
                $display("FAIL cyc_vga_data t=%0t got=%h exp=%h", $time, vga_rd_data, e_vd);
            end
        end
        checks++;
        if ({cam_overflow, hdr_overflow} !== {m_ovf[1], m_ovf[2]}) begin
            errors++;
            $display("FAIL cyc_overflow t=%0t got=%b%b exp=%b%b", $time,
                     cam_overflow, hdr_overflow, m_ovf[1], m_ovf[2]);
        end
        cam_wr_req = 1'b0; hdr_wr_req = 1'b0; vga_rd_req = 1'b0;
        cam_frame_start = 1'b0; hdr_frame_start = 1'b0; vga_frame_start = 1'b0;
        ram_rd_valid = rand_rd ? ($urandom_range(0, 3) == 0) : 1'b0;
        ram_rd_data  = rnd128();
        if (busy_left > 0) begin
            ram_busy = 1'b1;
            busy_left--;
        end else begin
            ram_busy = hold_busy;
        end
        if (e_wr || e_rd) busy_left = busy_len;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cam_wr_req = 1'b0; hdr_wr_req = 1'b0; vga_rd_req = 1'b0;
        cam_frame_start = 1'b0; hdr_frame_start = 1'b0; vga_frame_start = 1'b0;
        cam_wr_data = '0; hdr_wr_data = '0;
        ram_busy = 1'b0; ram_rd_valid = 1'b0; ram_rd_data = '0;
        model_reset();
        repeat (3) cycle();
        checks++;
        if ({ram_wr_req, ram_rd_req, vga_rd_valid, cam_overflow, hdr_overflow} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {ram_wr_req, ram_rd_req, vga_rd_valid, cam_overflow, hdr_overflow});
        end
        checks++;
        if (ram_addr !== '0 || ram_wr_data !== '0 || vga_rd_data !== '0) begin
            errors++;
            $display("FAIL reset_buses got addr=%0d wd=%h vd=%h exp=0", ram_addr, ram_wr_data,
                     vga_rd_data);
        end
        rst_n = 1'b1;
        repeat (2) cycle();
    endtask

    task automatic test_single_cam();
        logic [DW-1:0] d2;
        cam_wr_req  = 1'b1;
        cam_wr_data = {16{8'hA5}};
        cycle();
        checks++;
        if (ram_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL single_t1_idle got=%b exp=0", ram_wr_req);
        end
        cycle();
        checks++;
        if (ram_wr_req !== 1'b1 || ram_addr !== 22'd0 || ram_wr_data !== {16{8'hA5}}) begin
            errors++;
            $display("FAIL single_t2_issue got req=%b addr=%0d data=%h exp req=1 addr=0 data=a5..",
                     ram_wr_req, ram_addr, ram_wr_data);
        end
        repeat (6) cycle();
        d2 = rnd128();
        cam_wr_req  = 1'b1;
        cam_wr_data = d2;
        cycle();
        cycle();
        checks++;
        if (ram_wr_req !== 1'b1 || ram_addr !== 22'd1 || ram_wr_data !== d2) begin
            errors++;
            $display("FAIL single_second got req=%b addr=%0d data=%h exp req=1 addr=1 data=%h",
                     ram_wr_req, ram_addr, ram_wr_data, d2);
        end
        repeat (6) cycle();
    endtask

    task automatic test_priority();
        int            n = 0;
        int            cyc = 0;
        logic          kind [3];
        logic [AW-1:0] addr [3];
        int            at   [3];
        busy_len = 3;
        cam_frame_start = 1'b1; hdr_frame_start = 1'b1; vga_frame_start = 1'b1;
        cycle();
        repeat (4) cycle();
        cam_wr_req = 1'b1; hdr_wr_req = 1'b1; vga_rd_req = 1'b1;
        cam_wr_data = rnd128(); hdr_wr_data = rnd128();
        for (int k = 0; k < 40; k++) begin
            cycle();
            cyc++;
            if ((ram_wr_req || ram_rd_req) && n < 3) begin
                kind[n] = ram_wr_req;
                addr[n] = ram_addr;
                at[n]   = cyc;
                n++;
            end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL prio_count got=%0d exp=3", n);
        end else begin
            checks++;
            if ({kind[0], kind[1], kind[2]} !== 3'b011) begin
                errors++;
                $display("FAIL prio_order got wr-flags=%b exp=011", {kind[0], kind[1], kind[2]});
            end
            checks++;
            if (addr[0] !== 22'd38400 || addr[1] !== 22'd0 || addr[2] !== 22'd38400) begin
                errors++;
                $display("FAIL prio_addr got=%0d,%0d,%0d exp=38400,0,38400",
                         addr[0], addr[1], addr[2]);
            end
            checks++;
            if (at[1] - at[0] != busy_len + 2 || at[2] - at[1] != busy_len + 2) begin
                errors++;
                $display("FAIL prio_spacing got=%0d,%0d exp=%0d", at[1] - at[0], at[2] - at[1],
                         busy_len + 2);
            end
        end
    endtask

    task automatic test_read_fwd();
        ram_rd_valid = 1'b1;
        ram_rd_data  = {8{16'h1234}};
        cycle();
        checks++;
        if (vga_rd_valid !== 1'b1 || vga_rd_data !== {8{16'h1234}}) begin
            errors++;
            $display("FAIL rdfwd_data got v=%b d=%h exp v=1 d=1234..", vga_rd_valid, vga_rd_data);
        end
        cycle();
        checks++;
        if (vga_rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rdfwd_strobe got=%b exp=0", vga_rd_valid);
        end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] d1, d2, got;
        int            n = 0;
        d1 = rnd128();
        d2 = ~d1;
        hold_busy = 1'b1;
        ram_busy  = 1'b1;
        cycle();
        cam_wr_req = 1'b1; cam_wr_data = d1;
        cycle();
        cycle();
        cam_wr_req = 1'b1; cam_wr_data = d2;
        cycle();
        checks++;
        if (cam_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set got=%b exp=1", cam_overflow);
        end
        repeat (3) cycle();
        checks++;
        if (ram_wr_req !== 1'b0) begin
            errors++;
            $display("FAIL ovf_held got=%b exp=0", ram_wr_req);
        end
        hold_busy = 1'b0;
        got = '0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (ram_wr_req) begin
                n++;
                got = ram_wr_data;
            end
        end
        checks++;
        if (n != 1 || got !== d1) begin
            errors++;
            $display("FAIL ovf_first_only got n=%0d data=%h exp n=1 data=%h", n, got, d1);
        end
        checks++;
        if (cam_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got=%b exp=1", cam_overflow);
        end
    endtask

    task automatic test_wrap();
        int            n = 0;
        logic          fs_done = 1'b0;
        logic [AW-1:0] fs_addr = '0;
        int            after_fs = 0;
        busy_len = 0;
        hdr_frame_start = 1'b1;
        cycle();
        repeat (2) cycle();
        for (int k = 0; k < 80000 && after_fs < 2; k++) begin
            hdr_wr_req  = !m_pend[2];
            hdr_wr_data = rnd128();
            if (n >= 38405 && !fs_done && pred_win() == 2) begin
                hdr_frame_start = 1'b1;
                fs_addr = AW'(38400 + m_off[2]);
                fs_done = 1'b1;
            end
            cycle();
            if (ram_wr_req) begin
                n++;
                if (n == 38400) begin
                    checks++;
                    if (ram_addr !== 22'd76799) begin
                        errors++;
                        $display("FAIL wrap_last got=%0d exp=76799", ram_addr);
                    end
                end
                if (n == 38401) begin
                    checks++;
                    if (ram_addr !== 22'd38400) begin
                        errors++;
                        $display("FAIL wrap_first got=%0d exp=38400", ram_addr);
                    end
                end
                if (fs_done) begin
                    after_fs++;
                    checks++;
                    if (after_fs == 1 && ram_addr !== fs_addr) begin
                        errors++;
                        $display("FAIL fs_grant_addr got=%0d exp=%0d", ram_addr, fs_addr);
                    end else if (after_fs == 2 && ram_addr !== 22'd38400) begin
                        errors++;
                        $display("FAIL fs_next_addr got=%0d exp=38400", ram_addr);
                    end
                end
            end
        end
        checks++;
        if (after_fs != 2) begin
            errors++;
            $display("FAIL wrap_timeout got issues=%0d after_fs=%0d exp after_fs=2", n, after_fs);
        end
        repeat (4) cycle();
    endtask

    task automatic test_random();
        rand_rd = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            busy_len        = $urandom_range(0, 3);
            cam_wr_req      = ($urandom_range(0, 3) == 0);
            hdr_wr_req      = ($urandom_range(0, 3) == 0);
            vga_rd_req      = ($urandom_range(0, 5) == 0);
            cam_frame_start = ($urandom_range(0, 63) == 0);
            hdr_frame_start = ($urandom_range(0, 63) == 0);
            vga_frame_start = ($urandom_range(0, 63) == 0);
            cam_wr_data     = rnd128();
            hdr_wr_data     = rnd128();
            cycle();
        end
        rand_rd = 1'b0;
        repeat (8) cycle();
    endtask

    task automatic test_async_reset();
        int n = 0;
        busy_len = 2;
        cam_wr_req = 1'b1; hdr_wr_req = 1'b1;
        cam_wr_data = rnd128(); hdr_wr_data = rnd128();
        cycle();
        cycle();
        checks++;
        if (ram_wr_req !== 1'b1) begin
            errors++;
            $display("FAIL arst_precond got=%b exp=1", ram_wr_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ram_wr_req, ram_rd_req, vga_rd_valid, cam_overflow, hdr_overflow} !== 5'b0 ||
            ram_addr !== '0 || ram_wr_data !== '0) begin
            errors++;
            $display("FAIL arst_outputs got flags=%b addr=%0d wd=%h exp all 0",
                     {ram_wr_req, ram_rd_req, vga_rd_valid, cam_overflow, hdr_overflow},
                     ram_addr, ram_wr_data);
        end
        model_reset();
        busy_left = 0;
        ram_busy  = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            cycle();
            if (ram_wr_req || ram_rd_req) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL arst_no_issue got=%0d exp=0", n);
        end
    endtask

    initial begin
        test_reset();
        test_single_cam();
        test_priority();
        test_read_fwd();
        test_overflow();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frame_ram_arbiter.md
Name: frame_ram_arbiter

Overview:
- Shares the single SDRAM controller port between three clients: camera capture writes, tone-map (HDR) writes, and VGA display reads.
- Buffers one request per client and generates the per-client frame-buffer burst address.
- Issues one request at a time while the controller is idle. Priority is VGA read first, then round-robin between the two writers.
- Sits between the pixel pipelines and the SDRAM controller, replacing direct wr_req/ram_busy wiring.

Parameters:
- DATA_W, 128, burst data width (8 RGB565 pixels).
- ADDR_W, 22, burst address width.
- BURSTS_PER_FRAME, 38400, bursts per 640x480 frame (307200 px / 8).
- CAM_BASE, 0, camera frame base burst address.
- HDR_BASE, 38400, HDR frame base burst address.
- VGA_BASE, 38400, display read base burst address.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cam_wr_req  in  1  one-cycle pulse, camera burst ready
- cam_wr_data  in  DATA_W  camera burst, valid with cam_wr_req
- cam_frame_start  in  1  pulse, reset camera address offset
- hdr_wr_req  in  1  one-cycle pulse, HDR burst ready
- hdr_wr_data  in  DATA_W  HDR burst, valid with hdr_wr_req
- hdr_frame_start  in  1  pulse, reset HDR address offset
- vga_rd_req  in  1  one-cycle pulse, display needs a burst
- vga_frame_start  in  1  pulse, reset VGA address offset
- vga_rd_data  out  DATA_W  read burst to display
- vga_rd_valid  out  1  one-cycle strobe for vga_rd_data
- ram_busy  in  1  controller busy; rises the cycle after a request, falls when done
- ram_rd_valid  in  1  controller read data strobe
- ram_rd_data  in  DATA_W  controller read data
- ram_wr_req  out  1  one-cycle write request
- ram_rd_req  out  1  one-cycle read request
- ram_addr  out  ADDR_W  burst address, valid with request
- ram_wr_data  out  DATA_W  write data, valid with ram_wr_req
- cam_overflow  out  1  sticky: camera request dropped
- hdr_overflow  out  1  sticky: HDR request dropped

Behaviour:
- Reset (async, rst_n low) clears all registers. All outputs are 0, state is IDLE, round-robin pointer points to the camera, offsets are 0, and pending flags are 0.
- Client slot:
  - Request pulse sets pending and captures data.
  - If the request arrives while pending is already set and the slot is not being granted that cycle, the new request is dropped and the client's overflow flag is set.
  - VGA has no overflow flag; a duplicate VGA request is silently merged.
  - A request in the same cycle as that slot's grant is accepted: pending stays 1 with the new data.
- FSM:
  - IDLE: if ~ram_busy and any slot is pending, select a winner. VGA wins if pending; otherwise the round-robin pointer picks cam or hdr, falling back to the other if the pointed slot is empty.
  - Register ram_addr = base + offset, plus ram_wr_data for writes. Pulse ram_wr_req or ram_rd_req for exactly one cycle, clear the winner's pending flag, increment its offset, and go to GAP.
  - GAP: one cycle, ignore ram_busy, then return to IDLE. This guarantees the controller's busy rise is seen before the next issue.
  - Round-robin pointer toggles only when a write is granted.
- Latency: a request pulse at cycle t, with an idle controller and no competition, gives ram_*_req high at t+2.
- Offsets: range 0..BURSTS_PER_FRAME-1; wrap to 0 after the last burst. ram_addr arithmetic is unsigned ADDR_W; overflow is truncated.
- frame_start:
  - Forces that offset to 0 next cycle.
  - If it coincides with a grant of the same slot, the grant uses the old offset and the offset becomes 0 (frame_start wins over increment).
- Reads: ram_rd_valid/ram_rd_data are registered to vga_rd_valid/vga_rd_data (1-cycle latency). They are forwarded regardless of FSM state.
- Overflow flags clear only on reset.
- Reset asserted mid-transfer aborts immediately. Pending data is lost and no request pulse is emitted after reset deasserts until a new client request arrives.

Decomposition:
- Package frame_ram_pkg holds:
  - client ID encoding (CLI_VGA=0, CLI_CAM=1, CLI_HDR=2)
  - FSM state encoding (IDLE, GAP)
  - BURSTS_PER_FRAME and the base-address constants
- One sub-module: arb_client_slot, holding the pending flag, data buffer, overflow flag, and wrapping offset counter. It is instanced three times; the VGA instance has its data buffer tied off.

Test Plan:
- Single cam_wr_req with data 0xA5…A5, ram_busy=0 → ram_wr_req at t+2, ram_addr=0, ram_wr_data=0xA5…A5; second request → ram_addr=1.
- cam, hdr and vga requests in the same cycle → issue order vga (addr 38400, rd), cam (addr 0), hdr (addr 38400, wr), each separated by the controller's busy period.
- Two cam_wr_req pulses while ram_busy held high → second dropped, cam_overflow=1 and stays 1; on busy release only the first data is written.
- 38400 HDR writes → last ram_addr=76799, next ram_addr=38400 (wrap); hdr_frame_start coincident with a grant → granted address unchanged, next request uses offset 0.
- ram_rd_valid with data 0x1234… → vga_rd_valid and vga_rd_data 1 cycle later; rst_n pulsed low while GAP and a pending slot exist → all outputs 0 asynchronously, no request issued after release.
